// File: rtl/clock_tick_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clock_tick_monitor
//
// Brings a divided (slow) clock into the fast InputCLK domain as clock-enable
// ticks. The slow clock is treated as fully asynchronous: it is synchronised,
// edge-detected into single-cycle rise/fall ticks, and watched by a lock/loss
// watchdog so downstream logic can gate on clk_valid.
//
// Optional feature macro: CLOCK_TICK_MONITOR_MEASURE_EN
//   When defined, adds period / high_time measurement outputs.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on slow_clk (legal 2..4)
//   TIMEOUT      InputCLK cycles without any tick before a timeout (>= 4)
//   PERIOD_BITS  width of the measurement outputs
//
// Ports:
//   InputCLK    in   system clock, all logic on its rising edge
//   rst         in   asynchronous active-low reset
//   enable      in   synchronous run enable
//   slow_clk    in   divided clock, asynchronous to InputCLK
//   clear_lost  in   one-cycle pulse clearing clk_lost
//   clk_level   out  synchronised level of slow_clk
//   rise_tick   out  one-cycle pulse per slow_clk rising edge
//   fall_tick   out  one-cycle pulse per slow_clk falling edge
//   clk_valid   out  high while LOCKED
//   clk_lost    out  sticky flag: slow clock lost after lock
//   period      out  last rise-to-rise cycle count   (macro only)
//   high_time   out  last rise-to-fall cycle count   (macro only)
// -----------------------------------------------------------------------------
module clock_tick_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int PERIOD_BITS = 8
) (
  input  logic InputCLK,
  input  logic rst,
  input  logic enable,
  input  logic slow_clk,
  input  logic clear_lost,
  output logic clk_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic clk_valid,
  output logic clk_lost
`ifdef CLOCK_TICK_MONITOR_MEASURE_EN
  ,
  output logic [PERIOD_BITS-1:0] period,
  output logic [PERIOD_BITS-1:0] high_time
`endif
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKING, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_tick_q, rise_tick_d;
  logic                   fall_tick_q, fall_tick_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   clk_valid_q, clk_valid_d;
  logic                   clk_lost_q, clk_lost_d;
  logic                   level;
  logic                   run;
  logic                   timeout;

  assign level = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], slow_clk};
    prev_d      = level;
    state_d     = state_q;
    clk_lost_d  = clk_lost_q;

    run         = enable && (state_q != IDLE);
    rise_tick_d = run &&  level && !prev_q;
    fall_tick_d = run && !level &&  prev_q;

    // The gap counter is cleared on the edge that launches a tick, so it reads
    // 0 during the tick cycle and k in the k-th cycle after it. A tick that is
    // present blocks the timeout even when the counter is saturated.
    timeout = (gap_q == GAP_W'(TIMEOUT)) && !(rise_tick_q || fall_tick_q);

    if (!enable)                     gap_d = '0;
    else if (rise_tick_d || fall_tick_d) gap_d = '0;
    else if (gap_q != GAP_W'(TIMEOUT)) gap_d = gap_q + GAP_W'(1);
    else                             gap_d = gap_q;

    if (clear_lost) clk_lost_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (rise_tick_q) state_d = LOCKING;
        LOCKING: begin
          if (rise_tick_q)  state_d = LOCKED;
          else if (timeout) state_d = ACQUIRE;
        end
        LOCKED: begin
          if (timeout) begin
            state_d    = ACQUIRE;
            clk_lost_d = 1'b1;   // applied after the clear, so set wins
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered from the next state so clk_valid tracks the state register.
    clk_valid_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge InputCLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
      gap_q       <= '0;
      clk_valid_q <= 1'b0;
      clk_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
      gap_q       <= gap_d;
      clk_valid_q <= clk_valid_d;
      clk_lost_q  <= clk_lost_d;
    end
  end

  assign clk_level = level;
  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;
  assign clk_valid = clk_valid_q;
  assign clk_lost  = clk_lost_q;

`ifdef CLOCK_TICK_MONITOR_MEASURE_EN
  logic [PERIOD_BITS-1:0] meas_q, meas_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [PERIOD_BITS-1:0] high_q, high_d;
  logic                   meas_clear;
  logic                   in_lock;

  always_comb begin
    // Counter reads 1 in the cycle after a rise tick, so at the next rise it
    // holds the full rise-to-rise distance.
    if (rise_tick_q)          meas_d = PERIOD_BITS'(1);
    else if (meas_q != '1)    meas_d = meas_q + PERIOD_BITS'(1);
    else                      meas_d = meas_q;

    in_lock  = (state_q == LOCKING) || (state_q == LOCKED);
    period_d = period_q;
    high_d   = high_q;
    if (rise_tick_q && in_lock) period_d = meas_q;
    if (fall_tick_q && in_lock) high_d   = meas_q;

    meas_clear = (state_d == IDLE) ||
                 ((state_d == ACQUIRE) && (state_q != ACQUIRE));
    if (meas_clear) begin
      meas_d   = '0;
      period_d = '0;
      high_d   = '0;
    end
  end

  always_ff @(posedge InputCLK or negedge rst) begin
    if (!rst) begin
      meas_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      meas_q   <= meas_d;
      period_q <= period_d;
      high_q   <= high_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
`endif

endmodule
